time_of_day_counter: RTL and testbench

- Downstream consumer of the 2 Hz divided clock. Samples the divider's slow square-wave output as data in the i_clk domain and advances a 24-hour hh:mm:ss time in BCD.
- Provides run/pause, set-minute, set-hour and clear controls from debounced button pulses.
- Its BCD digits feed the 7-segment display driver.

---
 rtl/time_of_day_counter_pkg.sv | 29 ++
 rtl/bcd_digit_counter.sv | 32 +++
 rtl/time_of_day_counter.sv | 142 ++++++++++++++
 tb/tb_time_of_day_counter.sv | 216 +++++++++++++++++++++
 4 files changed

// File: rtl/time_of_day_counter_pkg.sv
// Shared constants for the time-of-day counter: BCD digit widths and terminal values.
// Latency: n/a (constants and an elaboration-time helper only).
// Backpressure: n/a.
package time_of_day_counter_pkg;

  // BCD digit widths
  localparam int SEC_ONES_W = 4;
  localparam int SEC_TENS_W = 3;
  localparam int MIN_ONES_W = 4;
  localparam int MIN_TENS_W = 3;
  localparam int HR_ONES_W  = 4;
  localparam int HR_TENS_W  = 2;

  // Terminal digit values
  localparam int ONES_MAX         = 9;
  localparam int SEC_TENS_MAX     = 5;
  localparam int MIN_TENS_MAX     = 5;
  localparam int HR_TENS_MAX      = 2;
  localparam int HR_ONES_MAX_AT_2 = 3;

  // Rising edges of the divider output per one-second advance (2 Hz square wave)
  localparam int DEFAULT_EDGES_PER_SEC = 2;

  // Edge counter width: ceil(log2(edges)), never below one bit
  function automatic int edge_cnt_width(input int edges);
    return (edges <= 2) ? 1 : $clog2(edges);
  endfunction

endpackage

// File: rtl/bcd_digit_counter.sv
// Single BCD digit that counts 0..MAX and wraps to 0, with a combinational carry-out.
// Latency: value updates on the clock edge after i_inc; o_carry is same-cycle.
// Backpressure: none; i_clr has priority over i_inc.
module bcd_digit_counter #(
  parameter int WIDTH = 4,
  parameter int MAX   = 9
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_inc,
  input  logic             i_clr,
  output logic [WIDTH-1:0] o_val,
  output logic             o_carry
);

  localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

  // Carry only when this digit is stepped while sitting on its terminal value
  assign o_carry = i_inc & (o_val == MAX_V);

  // Digit register: clear wins, otherwise step and wrap at MAX
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_val <= '0;
    end else if (i_clr) begin
      o_val <= '0;
    end else if (i_inc) begin
      o_val <= (o_val == MAX_V) ? '0 : o_val + WIDTH'(1);
    end
  end

endmodule

// File: rtl/time_of_day_counter.sv
// 24-hour hh:mm:ss BCD clock advanced by rising edges of a slow divider output sampled as data.
// Latency: digits and o_sec_pulse/o_day_wrap update on the edge ending the qualifying rise cycle.
// Backpressure: none; clear > set-minute/set-hour > timed advance, evaluated every cycle.
module time_of_day_counter
  import time_of_day_counter_pkg::*;
#(
  parameter int EDGES_PER_SEC = DEFAULT_EDGES_PER_SEC
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_tick,
  input  logic                  i_run,
  input  logic                  i_set_min,
  input  logic                  i_set_hr,
  input  logic                  i_clr,
  output logic [SEC_ONES_W-1:0] o_sec_ones,
  output logic [SEC_TENS_W-1:0] o_sec_tens,
  output logic [MIN_ONES_W-1:0] o_min_ones,
  output logic [MIN_TENS_W-1:0] o_min_tens,
  output logic [HR_ONES_W-1:0]  o_hr_ones,
  output logic [HR_TENS_W-1:0]  o_hr_tens,
  output logic                  o_sec_pulse,
  output logic                  o_day_wrap
);

  localparam int            CW        = edge_cnt_width(EDGES_PER_SEC);
  localparam logic [CW-1:0] EDGE_LAST = CW'(EDGES_PER_SEC - 1);

  logic          tick_d;
  logic [CW-1:0] edge_cnt;
  logic          rise;
  logic          set_any;
  logic          adv;
  logic          adv_eff;
  logic          sec_clr;
  logic          sec_ones_carry;
  logic          sec_tens_carry;
  logic          min_ones_carry;
  logic          min_tens_carry;
  logic          min_inc;
  logic          hr_timed;
  logic          hr_inc;
  logic          hr_at_max;

  assign rise    = i_tick & ~tick_d;
  assign set_any = i_set_min | i_set_hr;
  assign adv     = rise & i_run & (edge_cnt == EDGE_LAST);
  // A timed advance is dropped whenever a clear or a set lands in the same cycle
  assign adv_eff = adv & ~i_clr & ~set_any;
  assign sec_clr = i_clr | set_any;

  // Minute carry-out from a manual set must not reach the hours, so gate with the timed advance
  assign min_inc   = (i_set_min & ~i_clr) | sec_tens_carry;
  assign hr_timed  = adv_eff & min_tens_carry;
  assign hr_inc    = hr_timed | (i_set_hr & ~i_clr);
  assign hr_at_max = (o_hr_tens == HR_TENS_W'(HR_TENS_MAX)) &&
                     (o_hr_ones == HR_ONES_W'(HR_ONES_MAX_AT_2));

  // Sample the divider output and count qualifying rises toward one second
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      tick_d   <= 1'b0;
      edge_cnt <= '0;
    end else begin
      tick_d <= i_tick;
      if (sec_clr) begin
        edge_cnt <= '0;
      end else if (rise && i_run) begin
        edge_cnt <= (edge_cnt == EDGE_LAST) ? '0 : edge_cnt + CW'(1);
      end
    end
  end

  bcd_digit_counter #(.WIDTH(SEC_ONES_W), .MAX(ONES_MAX)) u_sec_ones (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_inc  (adv_eff),
    .i_clr  (sec_clr),
    .o_val  (o_sec_ones),
    .o_carry(sec_ones_carry)
  );

  bcd_digit_counter #(.WIDTH(SEC_TENS_W), .MAX(SEC_TENS_MAX)) u_sec_tens (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_inc  (sec_ones_carry),
    .i_clr  (sec_clr),
    .o_val  (o_sec_tens),
    .o_carry(sec_tens_carry)
  );

  bcd_digit_counter #(.WIDTH(MIN_ONES_W), .MAX(ONES_MAX)) u_min_ones (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_inc  (min_inc),
    .i_clr  (i_clr),
    .o_val  (o_min_ones),
    .o_carry(min_ones_carry)
  );

  bcd_digit_counter #(.WIDTH(MIN_TENS_W), .MAX(MIN_TENS_MAX)) u_min_tens (
    .i_clk  (i_clk),
    .i_rst  (i_rst),
    .i_inc  (min_ones_carry),
    .i_clr  (i_clr),
    .o_val  (o_min_tens),
    .o_carry(min_tens_carry)
  );

  // Hours step 0..9 per tens digit, except 23 which wraps straight to 00
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_hr_ones <= '0;
      o_hr_tens <= '0;
    end else if (i_clr) begin
      o_hr_ones <= '0;
      o_hr_tens <= '0;
    end else if (hr_inc) begin
      if (hr_at_max) begin
        o_hr_ones <= '0;
        o_hr_tens <= '0;
      end else if (o_hr_ones == HR_ONES_W'(ONES_MAX)) begin
        o_hr_ones <= '0;
        o_hr_tens <= o_hr_tens + HR_TENS_W'(1);
      end else begin
        o_hr_ones <= o_hr_ones + HR_ONES_W'(1);
      end
    end
  end

  // Registered strobes: only timed advances raise them, manual edits never do
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_sec_pulse <= 1'b0;
      o_day_wrap  <= 1'b0;
    end else begin
      o_sec_pulse <= adv_eff;
      o_day_wrap  <= hr_timed & hr_at_max;
    end
  end

endmodule

// File: tb/tb_time_of_day_counter.sv
// Directed self-checking bench for time_of_day_counter: vector table plus multi-cycle sequences.
// Latency: inputs driven on the falling edge, outputs sampled on the following falling edge.
// Backpressure: n/a.
module tb_time_of_day_counter;

  logic       i_clk     = 1'b0;
  logic       i_rst     = 1'b0;
  logic       i_tick    = 1'b0;
  logic       i_run     = 1'b0;
  logic       i_set_min = 1'b0;
  logic       i_set_hr  = 1'b0;
  logic       i_clr     = 1'b0;
  logic [3:0] o_sec_ones;
  logic [2:0] o_sec_tens;
  logic [3:0] o_min_ones;
  logic [2:0] o_min_tens;
  logic [3:0] o_hr_ones;
  logic [1:0] o_hr_tens;
  logic       o_sec_pulse;
  logic       o_day_wrap;

  logic [19:0] cur_time;
  assign cur_time = {o_hr_tens, o_hr_ones, o_min_tens, o_min_ones, o_sec_tens, o_sec_ones};

  time_of_day_counter #(.EDGES_PER_SEC(2)) dut (
    .i_clk      (i_clk),
    .i_rst      (i_rst),
    .i_tick     (i_tick),
    .i_run      (i_run),
    .i_set_min  (i_set_min),
    .i_set_hr   (i_set_hr),
    .i_clr      (i_clr),
    .o_sec_ones (o_sec_ones),
    .o_sec_tens (o_sec_tens),
    .o_min_ones (o_min_ones),
    .o_min_tens (o_min_tens),
    .o_hr_ones  (o_hr_ones),
    .o_hr_tens  (o_hr_tens),
    .o_sec_pulse(o_sec_pulse),
    .o_day_wrap (o_day_wrap)
  );

  always #5 i_clk = ~i_clk;

  int          n_checks  = 0;
  int          n_fail    = 0;
  int          pulse_cnt = 0;
  int          wrap_cnt  = 0;
  int          stray_cnt = 0;
  logic [19:0] s_time;
  logic        s_pulse;
  logic        s_wrap;

  typedef struct {
    string name;
    int    run, sm, sh, clr, rise;
    int    h, m, s;
    int    p, w;
  } vec_t;

  vec_t vecs[20];

  function automatic logic [19:0] bcd_time(input int h, input int m, input int s);
    logic [19:0] r;
    r = {2'(h / 10), 4'(h % 10), 3'(m / 10), 4'(m % 10), 3'(s / 10), 4'(s % 10)};
    return r;
  endfunction

  task automatic check(input string name, input logic [19:0] act, input logic [19:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // One action cycle with the given inputs, sample, then one idle cycle with tick low
  task automatic drive(input int run, input int sm, input int sh, input int clr, input int rise);
    @(negedge i_clk);
    i_run     = (run != 0);
    i_set_min = (sm != 0);
    i_set_hr  = (sh != 0);
    i_clr     = (clr != 0);
    i_tick    = (rise != 0);
    @(negedge i_clk);
    s_time    = cur_time;
    s_pulse   = o_sec_pulse;
    s_wrap    = o_day_wrap;
    pulse_cnt += int'(s_pulse);
    wrap_cnt  += int'(s_wrap);
    i_set_min = 1'b0;
    i_set_hr  = 1'b0;
    i_clr     = 1'b0;
    i_tick    = 1'b0;
    @(negedge i_clk);
    stray_cnt += int'(o_sec_pulse | o_day_wrap);
  endtask

  initial begin
    vecs[0]  = '{"rise1",           1, 0, 0, 0, 1,  0, 0, 0,  0, 0};
    vecs[1]  = '{"rise2",           1, 0, 0, 0, 1,  0, 0, 1,  1, 0};
    vecs[2]  = '{"rise3",           1, 0, 0, 0, 1,  0, 0, 1,  0, 0};
    vecs[3]  = '{"rise4",           1, 0, 0, 0, 1,  0, 0, 2,  1, 0};
    vecs[4]  = '{"pause_rise_a",    0, 0, 0, 0, 1,  0, 0, 2,  0, 0};
    vecs[5]  = '{"pause_rise_b",    0, 0, 0, 0, 1,  0, 0, 2,  0, 0};
    vecs[6]  = '{"resume_rise1",    1, 0, 0, 0, 1,  0, 0, 2,  0, 0};
    vecs[7]  = '{"resume_rise2",    1, 0, 0, 0, 1,  0, 0, 3,  1, 0};
    vecs[8]  = '{"clr",             1, 0, 0, 1, 0,  0, 0, 0,  0, 0};
    vecs[9]  = '{"rise_a",          1, 0, 0, 0, 1,  0, 0, 0,  0, 0};
    vecs[10] = '{"rise_b",          1, 0, 0, 0, 1,  0, 0, 1,  1, 0};
    vecs[11] = '{"rise_c",          1, 0, 0, 0, 1,  0, 0, 1,  0, 0};
    vecs[12] = '{"set_min_on_adv",  1, 1, 0, 0, 1,  0, 1, 0,  0, 0};
    vecs[13] = '{"post_set_rise1",  1, 0, 0, 0, 1,  0, 1, 0,  0, 0};
    vecs[14] = '{"post_set_rise2",  1, 0, 0, 0, 1,  0, 1, 1,  1, 0};
    vecs[15] = '{"clr_with_set_hr", 1, 0, 1, 1, 0,  0, 0, 0,  0, 0};
    vecs[16] = '{"set_hr",          1, 0, 1, 0, 0,  1, 0, 0,  0, 0};
    vecs[17] = '{"set_min_and_hr",  1, 1, 1, 0, 0,  2, 1, 0,  0, 0};
    vecs[18] = '{"set_min_paused",  0, 1, 0, 0, 0,  2, 2, 0,  0, 0};
    vecs[19] = '{"clr2",            1, 0, 0, 1, 0,  0, 0, 0,  0, 0};

    // Reset state
    @(negedge i_clk);
    check("reset_time", cur_time, bcd_time(0, 0, 0));
    check("reset_pulse", {19'b0, o_sec_pulse}, 20'd0);
    check("reset_wrap", {19'b0, o_day_wrap}, 20'd0);
    i_rst = 1'b1;
    i_run = 1'b1;

    // Vector table
    for (int k = 0; k < 20; k++) begin
      drive(vecs[k].run, vecs[k].sm, vecs[k].sh, vecs[k].clr, vecs[k].rise);
      check({vecs[k].name, "_time"}, s_time, bcd_time(vecs[k].h, vecs[k].m, vecs[k].s));
      check({vecs[k].name, "_pulse"}, {19'b0, s_pulse}, 20'(vecs[k].p));
      check({vecs[k].name, "_wrap"}, {19'b0, s_wrap}, 20'(vecs[k].w));
    end

    // Day wrap: preload 23:59:00, run to 23:59:59, then wrap
    for (int k = 0; k < 23; k++) drive(1, 0, 1, 0, 0);
    for (int k = 0; k < 59; k++) drive(1, 1, 0, 0, 0);
    check("preload_23_59_00", s_time, bcd_time(23, 59, 0));
    pulse_cnt = 0;
    wrap_cnt  = 0;
    for (int k = 0; k < 118; k++) drive(1, 0, 0, 0, 1);
    check("run_to_23_59_59", s_time, bcd_time(23, 59, 59));
    check("pulses_in_118_rises", 20'(pulse_cnt), 20'd59);
    check("no_early_wrap", 20'(wrap_cnt), 20'd0);
    drive(1, 0, 0, 0, 1);
    check("pre_wrap_time", s_time, bcd_time(23, 59, 59));
    check("pre_wrap_pulse", {19'b0, s_pulse}, 20'd0);
    drive(1, 0, 0, 0, 1);
    check("wrap_time", s_time, bcd_time(0, 0, 0));
    check("wrap_pulse", {19'b0, s_pulse}, 20'd1);
    check("wrap_strobe", {19'b0, s_wrap}, 20'd1);
    drive(1, 0, 0, 0, 0);
    check("post_wrap_pulse", {19'b0, s_pulse}, 20'd0);
    check("post_wrap_strobe", {19'b0, s_wrap}, 20'd0);

    // Set-minute at 00:59:30 wraps minutes only; then step hours through a full day
    for (int k = 0; k < 59; k++) drive(1, 1, 0, 0, 0);
    for (int k = 0; k < 60; k++) drive(1, 0, 0, 0, 1);
    check("at_00_59_30", s_time, bcd_time(0, 59, 30));
    drive(1, 1, 0, 0, 0);
    check("set_min_59_wrap", s_time, bcd_time(0, 0, 0));
    for (int k = 0; k < 24; k++) begin
      drive(1, 0, 1, 0, 0);
      check($sformatf("set_hr_step%0d", k + 1), s_time, bcd_time((k + 1) % 24, 0, 0));
    end

    // Paused for 10 rises, then edge count resumes from its held value of 0
    pulse_cnt = 0;
    for (int k = 0; k < 10; k++) drive(0, 0, 0, 0, 1);
    check("paused_time", s_time, bcd_time(0, 0, 0));
    check("paused_pulses", 20'(pulse_cnt), 20'd0);
    drive(1, 0, 0, 0, 1);
    check("resume_first_rise", s_time, bcd_time(0, 0, 0));
    check("resume_first_pulse", {19'b0, s_pulse}, 20'd0);
    drive(1, 0, 0, 0, 1);
    check("resume_second_rise", s_time, bcd_time(0, 0, 1));
    check("resume_second_pulse", {19'b0, s_pulse}, 20'd1);

    // Asynchronous reset mid-cycle at 12:34:56 while the second strobe is high
    drive(1, 0, 0, 1, 0);
    for (int k = 0; k < 12; k++) drive(1, 0, 1, 0, 0);
    for (int k = 0; k < 34; k++) drive(1, 1, 0, 0, 0);
    for (int k = 0; k < 111; k++) drive(1, 0, 0, 0, 1);
    check("at_12_34_55", s_time, bcd_time(12, 34, 55));
    @(negedge i_clk);
    i_run  = 1'b1;
    i_tick = 1'b1;
    @(posedge i_clk);
    #2;
    check("at_12_34_56", cur_time, bcd_time(12, 34, 56));
    check("pulse_before_reset", {19'b0, o_sec_pulse}, 20'd1);
    i_rst = 1'b0;
    #1;
    check("async_reset_time", cur_time, bcd_time(0, 0, 0));
    check("async_reset_pulse", {19'b0, o_sec_pulse}, 20'd0);
    check("async_reset_wrap", {19'b0, o_day_wrap}, 20'd0);
    @(negedge i_clk);
    i_tick = 1'b0;
    i_rst  = 1'b1;
    drive(1, 0, 0, 0, 1);
    check("post_reset_rise1", s_time, bcd_time(0, 0, 0));
    check("post_reset_pulse1", {19'b0, s_pulse}, 20'd0);
    drive(1, 0, 0, 0, 1);
    check("post_reset_rise2", s_time, bcd_time(0, 0, 1));
    check("post_reset_pulse2", {19'b0, s_pulse}, 20'd1);

    // Strobes must never linger into the idle cycle after an action
    check("idle_strobes", 20'(stray_cnt), 20'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
